// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory bus between the instruction-fetch port (I, read-only)
//   and the memory-stage port (D, read/write). One transaction is in flight
//   at a time; read data is steered back to the port that issued it.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   i_valid/i_addr/i_abort          fetch request, redirect abort pulse
//   i_done/i_rdata                  fetch completion pulse and data
//   d_valid/d_we/d_addr/d_wdata/d_strb  data request
//   d_done/d_rdata                  data completion pulse and load data
//   stall_if/stall_mem              pipeline stage-enable gates
//   mem_req/mem_we/mem_addr/mem_wdata/mem_strb  bus request (registered)
//   mem_addr_ok/mem_data_ok/mem_rdata           bus handshake and read data
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_abort,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_valid,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_strb,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_strb,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t              r_state;
    owner_t              r_owner;
    logic                r_drop;
    logic [CNT_W-1:0]    r_starve;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]   r_mem_strb;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_grant_d;
    logic w_grant_i;
    logic w_capture;
    logic w_abort_hit;

    // D normally wins; once it has won STARVE_MAX times in a row while
    // fetch was waiting, fetch gets the next slot.
    assign w_grant_d   = (r_state == S_IDLE) && d_valid &&
                         ((r_starve < STARVE_LIM) || !i_valid);
    assign w_grant_i   = (r_state == S_IDLE) && !w_grant_d && i_valid;
    // Response accepted either alongside the address handshake or later.
    assign w_capture   = ((r_state == S_REQ) && mem_addr_ok && mem_data_ok) ||
                         ((r_state == S_WAIT) && mem_data_ok);
    assign w_abort_hit = i_abort && (r_owner == OWN_I) && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_NONE;
            r_drop      <= 1'b0;
            r_starve    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_strb  <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            // Starvation counter: only D wins over a waiting fetch count.
            if (w_grant_d && i_valid)
                r_starve <= (r_starve == STARVE_LIM) ? r_starve : r_starve + 1'b1;
            else if (w_grant_i || !i_valid)
                r_starve <= '0;

            // Leaving RESP clears drop; that wins over an abort in RESP.
            if (r_state == S_RESP)
                r_drop <= 1'b0;
            else if (w_abort_hit)
                r_drop <= 1'b1;

            // Aborted fetches still write i_rdata; only the done is hidden.
            if (w_capture) begin
                if (r_owner == OWN_I)
                    r_i_rdata <= mem_rdata;
                else if ((r_owner == OWN_D) && !r_mem_we)
                    r_d_rdata <= mem_rdata;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_owner     <= OWN_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_strb  <= d_strb;
                        r_state     <= S_REQ;
                    end else if (w_grant_i) begin
                        r_owner     <= OWN_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= '0;
                        r_mem_strb  <= '1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= mem_data_ok ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_data_ok)
                        r_state <= S_RESP;
                end
                S_RESP: begin
                    r_owner <= OWN_NONE;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // i_abort in RESP must hide this cycle's i_done, hence the live term.
    assign i_done    = (r_state == S_RESP) && (r_owner == OWN_I) && !r_drop && !i_abort;
    assign d_done    = (r_state == S_RESP) && (r_owner == OWN_D);
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_if  = i_valid & ~i_done;
    assign stall_mem = d_valid & ~d_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_strb  = r_mem_strb;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory bus between instruction fetch (I side, read-only) and the memory stage (D side, read/write).
- Serializes transactions with one outstanding at a time and returns read data to the requester that issued it.
- Drives stall_if and stall_mem, which the pipeline uses to gate its stage register enables.
- Handles fetch redirects: an aborted instruction fetch still completes on the bus, but its response is dropped.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- STARVE_MAX, 4, number of consecutive D grants while I is waiting, after which I wins the next arbitration.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- i_valid  in  1  fetch request; held with i_addr stable until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_abort  in  1  one-cycle pulse: discard the in-flight fetch response.
- i_done  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  DATA_W  fetched word.
- d_valid  in  1  data request; held with fields stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_strb  in  DATA_W/8  byte enables for stores.
- d_done  out  1  one-cycle pulse; d_rdata valid for loads.
- d_rdata  out  DATA_W  load data.
- stall_if  out  1  equals i_valid & ~i_done.
- stall_mem  out  1  equals d_valid & ~d_done.
- mem_req  out  1  bus request.
- mem_we, mem_addr, mem_wdata, mem_strb  out  various  registered copies of the granted request's fields.
- mem_addr_ok  in  1  bus accepts the request this cycle.
- mem_data_ok  in  1  bus response this cycle.
- mem_rdata  in  DATA_W  bus read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset values: state = IDLE, owner = none, drop = 0, starve counter = 0. All outputs 0, except stall_* which follow their combinational equations.
- IDLE, arbitration:
  - If d_valid and (starve < STARVE_MAX or !i_valid): grant D.
  - Else if i_valid: grant I.
  - On a grant: latch fields into the mem_* registers and go to REQ.
  - I requests drive mem_we = 0 and mem_strb = all ones.
- Starve counter:
  - Increments on each D grant made while i_valid = 1.
  - Clears on an I grant or when i_valid = 0.
  - Saturates at STARVE_MAX.
- REQ:
  - mem_req = 1, and it is never withdrawn before mem_addr_ok.
  - mem_addr_ok alone: go to WAIT.
  - mem_addr_ok and mem_data_ok in the same cycle: capture mem_rdata and go to RESP.
- WAIT:
  - mem_req = 0.
  - mem_data_ok: capture mem_rdata into the owner's rdata register and go to RESP.
  - mem_data_ok is ignored in IDLE and REQ (when addr_ok is absent) and in RESP.
- RESP:
  - Owner's done = 1 for exactly one cycle, then go to IDLE.
  - If owner = I and drop = 1, i_done stays 0. drop clears on leaving RESP.
  - No arbitration happens in RESP, so a requester still holding valid is not re-granted.
- Latency with a zero-wait bus: grant cycle → REQ → RESP gives done 2 cycles after the grant. The minimum spacing between grants is 3 cycles.
- i_abort:
  - Sets drop when owner = I and state is REQ, WAIT or RESP.
  - In RESP, abort suppresses that cycle's i_done combinationally.
  - Ignored when owner = D or state = IDLE.
- d_rdata holds its value after a store (not updated). rdata outputs hold their value between transactions.
- Reset asserted mid-transaction: return to IDLE immediately, deassert mem_req, lose the transaction, issue no done.

Test Plan:
- Only d_valid, load addr 0x100; bus gives addr_ok in REQ and data_ok 1 cycle later with 0xDEADBEEF -> mem_req high 1 cycle; d_done pulses once with d_rdata = 0xDEADBEEF; stall_mem low the cycle after.
- i_valid and d_valid (store 0x200, wdata 0x12345678, strb 0x3) together -> D granted first with mem_we = 1 and mem_strb = 0x3; I granted next; i_done never coincides with d_done.
- d_valid continuously re-raised while i_valid is held, STARVE_MAX = 4 -> 4 D grants, then 1 I grant; the counter then clears.
- i_abort pulsed while state = WAIT with owner = I -> bus transaction completes; i_done stays 0; next i_valid addr 0x40 is served normally.
- addr_ok and data_ok in the same cycle -> RESP reached directly; done pulses on the next cycle.
- resetn dropped while in WAIT -> outputs are 0 and state is IDLE asynchronously; no done after release.
